// File: rtl/xif_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xif_seq_pkg
// Description : Shared types for the X-interface coprocessor sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package xif_seq_pkg;

    // Entries carry the widest supported ID; narrower IDs are zero-extended.
    localparam int c_id_w_max = 16;

    typedef enum logic [1:0] {
        ISSUED    = 2'd0,
        COMMITTED = 2'd1,
        KILLED    = 2'd2
    } entry_state_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        WAIT_RES = 2'd2,
        RESULT   = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic                  valid;
        logic [c_id_w_max-1:0] id;
        entry_state_e          state;
    } entry_t;

    function automatic logic entry_is(input logic valid, input entry_state_e state,
                                      input entry_state_e want);
        return valid && (state == want);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xif_coproc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : xif_coproc_sequencer_if
// Description : Issue/commit/exec/result handshake bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface xif_coproc_sequencer_if #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32
);
    logic                   issue_valid_i;
    logic                   issue_ready_o;
    logic [X_ID_WIDTH-1:0]  issue_id_i;
    logic                   dec_accept_i;
    logic                   commit_valid_i;
    logic [X_ID_WIDTH-1:0]  commit_id_i;
    logic                   commit_kill_i;
    logic                   exec_valid_o;
    logic                   exec_ready_i;
    logic [X_ID_WIDTH-1:0]  exec_id_o;
    logic                   exec_rvalid_i;
    logic [X_RFW_WIDTH-1:0] exec_rdata_i;
    logic                   result_valid_o;
    logic                   result_ready_i;
    logic [X_ID_WIDTH-1:0]  result_id_o;
    logic [X_RFW_WIDTH-1:0] result_data_o;
    logic                   err_o;

    // Coprocessor side
    modport slave (
        input  issue_valid_i, issue_id_i, dec_accept_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        input  exec_ready_i, exec_rvalid_i, exec_rdata_i, result_ready_i,
        output issue_ready_o, exec_valid_o, exec_id_o,
        output result_valid_o, result_id_o, result_data_o, err_o
    );

    // CPU / execution-unit side
    modport master (
        output issue_valid_i, issue_id_i, dec_accept_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        output exec_ready_i, exec_rvalid_i, exec_rdata_i, result_ready_i,
        input  issue_ready_o, exec_valid_o, exec_id_o,
        input  result_valid_o, result_id_o, result_data_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/xif_coproc_sequencer_table.sv
`default_nettype none
// ============================================================================
// Module      : xif_seq_table
// Description : Circular tracking table with CAM commit match and duplicate
//               ID detection.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_seq_table
    import xif_seq_pkg::*;
#(
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic                  i_push,
    input  wire logic [X_ID_WIDTH-1:0] i_push_id,
    input  wire logic                  i_commit_valid,
    input  wire logic [X_ID_WIDTH-1:0] i_commit_id,
    input  wire logic                  i_commit_kill,
    input  wire logic                  i_pop,
    output logic                       o_not_full,
    output logic                       o_head_valid,
    output logic [X_ID_WIDTH-1:0]      o_head_id,
    output entry_state_e               o_head_state,
    output logic                       o_commit_miss,
    output logic                       o_push_dup
);
    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    entry_t                  r_entries [DEPTH];
    logic [c_ptr_w-1:0]      r_head;
    logic [c_ptr_w-1:0]      r_tail;
    logic [c_ptr_w:0]        r_count;

    logic [c_id_w_max-1:0]   w_push_id;
    logic [c_id_w_max-1:0]   w_commit_id;
    logic [DEPTH-1:0]        w_match;
    logic [DEPTH-1:0]        w_dup;
    logic                    w_push_match;
    entry_state_e            w_resolved;

    assign w_push_id   = c_id_w_max'(i_push_id);
    assign w_commit_id = c_id_w_max'(i_commit_id);
    assign w_resolved  = i_commit_kill ? KILLED : COMMITTED;

    // A commit may target the entry being pushed in the same cycle.
    assign w_push_match = i_commit_valid && i_push && (w_commit_id == w_push_id);

    always_comb begin
        w_match = '0;
        w_dup   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = i_commit_valid && r_entries[i].valid &&
                         (r_entries[i].state == ISSUED) &&
                         (r_entries[i].id == w_commit_id);
            w_dup[i]   = r_entries[i].valid && (r_entries[i].id == w_push_id);
        end
    end

    assign o_commit_miss = i_commit_valid && !(|w_match) && !w_push_match;
    assign o_push_dup    = i_push && (|w_dup);

    assign o_not_full   = (r_count != c_depth);
    assign o_head_valid = r_entries[r_head].valid;
    assign o_head_id    = r_entries[r_head].id[X_ID_WIDTH-1:0];
    assign o_head_state = r_entries[r_head].state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '{valid: 1'b0, id: '0, state: ISSUED};
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_match[i]) begin
                    r_entries[i].state <= w_resolved;
                end
            end
            if (i_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + 1'b1;
            end
            if (i_push) begin
                r_entries[r_tail] <= '{valid: 1'b1, id: w_push_id,
                                       state: (w_push_match ? w_resolved : ISSUED)};
                r_tail            <= r_tail + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/xif_coproc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xif_coproc_sequencer
// Description : In-order single-unit dispatcher and result return path for
//               the CORE-V eXtension interface.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_coproc_sequencer
    import xif_seq_pkg::*;
#(
    parameter int X_ID_WIDTH  = 4,
    parameter int DEPTH       = 4,
    parameter int X_RFW_WIDTH = 32
) (
    input  wire logic               clk_i,
    input  wire logic               rst_ni,
    xif_coproc_sequencer_if.slave   bus
);
    localparam logic [1:0] c_st_idle     = IDLE;
    localparam logic [1:0] c_st_dispatch = DISPATCH;
    localparam logic [1:0] c_st_wait     = WAIT_RES;
    localparam logic [1:0] c_st_result   = RESULT;

    logic [1:0]             r_state;
    logic [X_ID_WIDTH-1:0]  r_res_id;
    logic [X_RFW_WIDTH-1:0] r_res_data;
    logic                   r_err;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_not_full;
    logic                   w_head_valid;
    logic [X_ID_WIDTH-1:0]  w_head_id;
    entry_state_e           w_head_state;
    logic                   w_commit_miss;
    logic                   w_push_dup;
    logic                   w_head_commit;
    logic                   w_head_kill;
    logic                   w_exec_valid;
    logic                   w_exec_fire;
    logic                   w_stray_rvalid;
    logic                   w_result_valid;

    assign w_push = bus.issue_valid_i && w_not_full && bus.dec_accept_i;

    xif_seq_table #(
        .X_ID_WIDTH (X_ID_WIDTH),
        .DEPTH      (DEPTH)
    ) u_table (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .i_push         (w_push),
        .i_push_id      (bus.issue_id_i),
        .i_commit_valid (bus.commit_valid_i),
        .i_commit_id    (bus.commit_id_i),
        .i_commit_kill  (bus.commit_kill_i),
        .i_pop          (w_pop),
        .o_not_full     (w_not_full),
        .o_head_valid   (w_head_valid),
        .o_head_id      (w_head_id),
        .o_head_state   (w_head_state),
        .o_commit_miss  (w_commit_miss),
        .o_push_dup     (w_push_dup)
    );

    assign w_head_commit = entry_is(w_head_valid, w_head_state, COMMITTED);
    assign w_head_kill   = entry_is(w_head_valid, w_head_state, KILLED);

    // IDLE offers a committed head immediately so dispatch follows commit by
    // one cycle; DISPATCH only holds the request when it was not taken.
    assign w_exec_valid   = (r_state == c_st_dispatch) ||
                            ((r_state == c_st_idle) && w_head_commit);
    assign w_exec_fire    = w_exec_valid && bus.exec_ready_i;
    assign w_pop          = w_exec_fire || ((r_state == c_st_idle) && w_head_kill);
    assign w_stray_rvalid = bus.exec_rvalid_i && (r_state != c_st_wait);
    assign w_result_valid = (r_state == c_st_result);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= c_st_idle;
            r_res_id   <= '0;
            r_res_data <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_exec_fire) begin
                        r_res_id <= w_head_id;
                        r_state  <= c_st_wait;
                    end else if (w_head_commit) begin
                        r_state  <= c_st_dispatch;
                    end
                end
                c_st_dispatch: begin
                    if (bus.exec_ready_i) begin
                        r_res_id <= w_head_id;
                        r_state  <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (bus.exec_rvalid_i) begin
                        r_res_data <= bus.exec_rdata_i;
                        r_state    <= c_st_result;
                    end
                end
                c_st_result: begin
                    if (bus.result_ready_i) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_commit_miss || w_push_dup || w_stray_rvalid) begin
            r_err <= 1'b1;
        end
    end

    assign bus.issue_ready_o  = w_not_full;
    assign bus.exec_valid_o   = w_exec_valid;
    assign bus.exec_id_o      = w_exec_valid ? w_head_id : '0;
    assign bus.result_valid_o = w_result_valid;
    assign bus.result_id_o    = w_result_valid ? r_res_id : '0;
    assign bus.result_data_o  = w_result_valid ? r_res_data : '0;
    assign bus.err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xif_coproc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xif_coproc_sequencer
// Description : Directed vector-table bench for xif_coproc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xif_coproc_sequencer;

    typedef struct {
        logic        iv;
        logic [3:0]  iid;
        logic        acc;
        logic        cv;
        logic [3:0]  cid;
        logic        ck;
        logic        er;
        logic        rv;
        logic [31:0] rd;
        logic        rr;
        logic        e_ir;
        logic        e_ev;
        logic [3:0]  e_eid;
        logic        e_rv;
        logic [3:0]  e_rid;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    xif_coproc_sequencer_if #(.X_ID_WIDTH(4), .X_RFW_WIDTH(32)) bus ();

    xif_coproc_sequencer #(
        .X_ID_WIDTH  (4),
        .DEPTH       (4),
        .X_RFW_WIDTH (32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    function automatic vec_t v(
        input logic iv, input logic [3:0] iid, input logic acc,
        input logic cv, input logic [3:0] cid, input logic ck,
        input logic er, input logic rv, input logic [31:0] rd, input logic rr,
        input logic e_ir, input logic e_ev, input logic [3:0] e_eid,
        input logic e_rv, input logic [3:0] e_rid, input logic [31:0] e_rd,
        input logic e_err);
        vec_t r;
        r.iv = iv;     r.iid = iid;     r.acc = acc;
        r.cv = cv;     r.cid = cid;     r.ck = ck;
        r.er = er;     r.rv = rv;       r.rd = rd;     r.rr = rr;
        r.e_ir = e_ir; r.e_ev = e_ev;   r.e_eid = e_eid;
        r.e_rv = e_rv; r.e_rid = e_rid; r.e_rd = e_rd; r.e_err = e_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        bus.issue_valid_i  = 1'b0;
        bus.issue_id_i     = '0;
        bus.dec_accept_i   = 1'b0;
        bus.commit_valid_i = 1'b0;
        bus.commit_id_i    = '0;
        bus.commit_kill_i  = 1'b0;
        bus.exec_ready_i   = 1'b0;
        bus.exec_rvalid_i  = 1'b0;
        bus.exec_rdata_i   = '0;
        bus.result_ready_i = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic chk_all(input string tag, input logic ir, input logic ev, input logic [3:0] eid,
                           input logic rv, input logic [3:0] rid, input logic [31:0] rd,
                           input logic err);
        chk({tag, " issue_ready"},  32'(bus.issue_ready_o),  32'(ir));
        chk({tag, " exec_valid"},   32'(bus.exec_valid_o),   32'(ev));
        chk({tag, " exec_id"},      32'(bus.exec_id_o),      32'(eid));
        chk({tag, " result_valid"}, 32'(bus.result_valid_o), 32'(rv));
        chk({tag, " result_id"},    32'(bus.result_id_o),    32'(rid));
        chk({tag, " result_data"},  bus.result_data_o,       rd);
        chk({tag, " err"},          32'(bus.err_o),          32'(err));
    endtask

    vec_t vecs [24];

    initial begin
        // Single instruction round trip, then out-of-order commit / kill.
        vecs[0]  = v(1,3,1, 1,3,0, 1,0,0,0,            1,0,0, 0,0,0,0);
        vecs[1]  = v(0,0,0, 0,0,0, 1,0,0,0,            1,1,3, 0,0,0,0);
        vecs[2]  = v(0,0,0, 0,0,0, 0,1,32'hDEADBEEF,0, 1,0,0, 0,0,0,0);
        vecs[3]  = v(0,0,0, 0,0,0, 0,0,0,0,            1,0,0, 1,3,32'hDEADBEEF,0);
        vecs[4]  = v(0,0,0, 0,0,0, 0,0,0,0,            1,0,0, 1,3,32'hDEADBEEF,0);
        vecs[5]  = v(0,0,0, 0,0,0, 0,0,0,0,            1,0,0, 1,3,32'hDEADBEEF,0);
        vecs[6]  = v(0,0,0, 0,0,0, 0,0,0,1,            1,0,0, 1,3,32'hDEADBEEF,0);
        vecs[7]  = v(0,0,0, 0,0,0, 0,0,0,0,            1,0,0, 0,0,0,0);
        vecs[8]  = v(1,1,1, 0,0,0, 0,0,0,0,            1,0,0, 0,0,0,0);
        vecs[9]  = v(1,2,1, 0,0,0, 0,0,0,0,            1,0,0, 0,0,0,0);
        vecs[10] = v(1,3,1, 0,0,0, 0,0,0,0,            1,0,0, 0,0,0,0);
        vecs[11] = v(0,0,0, 1,2,0, 1,0,0,0,            1,0,0, 0,0,0,0);
        vecs[12] = v(0,0,0, 0,0,0, 1,0,0,0,            1,0,0, 0,0,0,0);
        vecs[13] = v(0,0,0, 1,1,1, 1,0,0,0,            1,0,0, 0,0,0,0);
        vecs[14] = v(0,0,0, 1,3,0, 1,0,0,0,            1,0,0, 0,0,0,0);
        vecs[15] = v(0,0,0, 0,0,0, 0,0,0,0,            1,1,2, 0,0,0,0);
        vecs[16] = v(0,0,0, 0,0,0, 0,0,0,0,            1,1,2, 0,0,0,0);
        vecs[17] = v(0,0,0, 0,0,0, 1,0,0,0,            1,1,2, 0,0,0,0);
        vecs[18] = v(0,0,0, 0,0,0, 0,1,32'h22,0,       1,0,0, 0,0,0,0);
        vecs[19] = v(0,0,0, 0,0,0, 0,0,0,1,            1,0,0, 1,2,32'h22,0);
        vecs[20] = v(0,0,0, 0,0,0, 1,0,0,0,            1,1,3, 0,0,0,0);
        vecs[21] = v(0,0,0, 0,0,0, 0,1,32'h33,0,       1,0,0, 0,0,0,0);
        vecs[22] = v(0,0,0, 0,0,0, 0,0,0,1,            1,0,0, 1,3,32'h33,0);
        vecs[23] = v(0,0,0, 0,0,0, 0,0,0,0,            1,0,0, 0,0,0,0);

        clr_in();
        @(negedge clk);
        chk_all("reset", 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 24; i++) begin
            bus.issue_valid_i  = vecs[i].iv;
            bus.issue_id_i     = vecs[i].iid;
            bus.dec_accept_i   = vecs[i].acc;
            bus.commit_valid_i = vecs[i].cv;
            bus.commit_id_i    = vecs[i].cid;
            bus.commit_kill_i  = vecs[i].ck;
            bus.exec_ready_i   = vecs[i].er;
            bus.exec_rvalid_i  = vecs[i].rv;
            bus.exec_rdata_i   = vecs[i].rd;
            bus.result_ready_i = vecs[i].rr;
            @(negedge clk);
            chk_all($sformatf("row%0d", i), vecs[i].e_ir, vecs[i].e_ev, vecs[i].e_eid,
                    vecs[i].e_rv, vecs[i].e_rid, vecs[i].e_rd, vecs[i].e_err);
            cyc();
        end
        clr_in();

        // Fill the table, drain one entry, then kill the rest.
        for (int id = 0; id < 4; id++) begin
            bus.issue_valid_i = 1'b1;
            bus.dec_accept_i  = 1'b1;
            bus.issue_id_i    = 4'(id);
            cyc();
        end
        bus.issue_id_i = 4'd9;
        @(negedge clk);
        chk("full issue_ready", 32'(bus.issue_ready_o), 32'd0);
        cyc();
        clr_in();
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = 4'd0;
        @(negedge clk);
        chk("full exec_valid before commit", 32'(bus.exec_valid_o), 32'd0);
        cyc();
        clr_in();
        bus.exec_ready_i = 1'b1;
        @(negedge clk);
        chk("full exec_valid", 32'(bus.exec_valid_o), 32'd1);
        chk("full exec_id", 32'(bus.exec_id_o), 32'd0);
        chk("issue_ready in pop cycle", 32'(bus.issue_ready_o), 32'd0);
        cyc();
        clr_in();
        bus.exec_rvalid_i = 1'b1;
        bus.exec_rdata_i  = 32'h1234_5678;
        @(negedge clk);
        chk("issue_ready after pop", 32'(bus.issue_ready_o), 32'd1);
        chk("exec_valid in wait", 32'(bus.exec_valid_o), 32'd0);
        cyc();
        clr_in();
        bus.result_ready_i = 1'b1;
        @(negedge clk);
        chk_all("full result", 1, 0, 0, 1, 0, 32'h1234_5678, 0);
        cyc();
        clr_in();
        for (int id = 1; id < 4; id++) begin
            bus.commit_valid_i = 1'b1;
            bus.commit_kill_i  = 1'b1;
            bus.commit_id_i    = 4'(id);
            cyc();
        end
        clr_in();
        cyc();
        bus.issue_valid_i  = 1'b1;
        bus.dec_accept_i   = 1'b1;
        bus.issue_id_i     = 4'd6;
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = 4'd6;
        cyc();
        clr_in();
        bus.exec_ready_i = 1'b1;
        @(negedge clk);
        chk("after kills exec_valid", 32'(bus.exec_valid_o), 32'd1);
        chk("after kills exec_id", 32'(bus.exec_id_o), 32'd6);
        cyc();
        clr_in();
        bus.exec_rvalid_i = 1'b1;
        bus.exec_rdata_i  = 32'h0000_0066;
        cyc();
        clr_in();
        bus.result_ready_i = 1'b1;
        @(negedge clk);
        chk_all("id6 result", 1, 0, 0, 1, 6, 32'h66, 0);
        cyc();
        clr_in();

        // Instruction not claimed by the decoder, then committed anyway.
        bus.issue_valid_i = 1'b1;
        bus.issue_id_i    = 4'd5;
        cyc();
        clr_in();
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = 4'd5;
        @(negedge clk);
        chk("err before miss", 32'(bus.err_o), 32'd0);
        cyc();
        clr_in();
        bus.exec_ready_i = 1'b1;
        @(negedge clk);
        chk("miss err", 32'(bus.err_o), 32'd1);
        chk("miss exec_valid", 32'(bus.exec_valid_o), 32'd0);
        cyc();
        @(negedge clk);
        chk("miss exec_valid later", 32'(bus.exec_valid_o), 32'd0);
        chk("miss issue_ready", 32'(bus.issue_ready_o), 32'd1);
        cyc();
        clr_in();

        // Duplicate ID and stray execution result.
        do_reset();
        chk("err cleared by reset", 32'(bus.err_o), 32'd0);
        bus.issue_valid_i = 1'b1;
        bus.dec_accept_i  = 1'b1;
        bus.issue_id_i    = 4'd7;
        cyc();
        @(negedge clk);
        chk("dup err after first", 32'(bus.err_o), 32'd0);
        cyc();
        clr_in();
        @(negedge clk);
        chk("dup err", 32'(bus.err_o), 32'd1);
        bus.exec_rvalid_i = 1'b1;
        bus.exec_rdata_i  = 32'hBAD0_0BAD;
        cyc();
        clr_in();
        @(negedge clk);
        chk("stray rvalid result_valid", 32'(bus.result_valid_o), 32'd0);
        chk("stray rvalid err", 32'(bus.err_o), 32'd1);
        cyc();

        // Asynchronous reset while a result is pending and entries are queued.
        do_reset();
        bus.issue_valid_i  = 1'b1;
        bus.dec_accept_i   = 1'b1;
        bus.issue_id_i     = 4'd1;
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = 4'd1;
        cyc();
        bus.commit_valid_i = 1'b0;
        bus.issue_id_i     = 4'd4;
        bus.exec_ready_i   = 1'b1;
        @(negedge clk);
        chk("rst seq exec_id", 32'(bus.exec_id_o), 32'd1);
        cyc();
        bus.issue_id_i    = 4'd5;
        bus.exec_ready_i  = 1'b0;
        bus.exec_rvalid_i = 1'b1;
        bus.exec_rdata_i  = 32'hCAFE_0001;
        cyc();
        clr_in();
        @(negedge clk);
        chk("rst seq result_valid", 32'(bus.result_valid_o), 32'd1);
        chk("rst seq result_id", 32'(bus.result_id_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async reset", 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.result_ready_i = 1'b1;
        bus.exec_ready_i   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("post reset %0d result_valid", k), 32'(bus.result_valid_o), 32'd0);
            chk($sformatf("post reset %0d exec_valid", k), 32'(bus.exec_valid_o), 32'd0);
        end
        clr_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
